// File: rtl/sfq_toggle_rx.sv
// Toggle-encoded SFQ pulse receiver: resync, timing-window FSM, small output FIFO.
// Define SFQRX_TIMESTAMP_EN to store cycle-counter timestamps instead of pulse sequence numbers.
module sfq_toggle_rx #(
   parameter int CT_CYCLES  = 7,
   parameter int FIFO_DEPTH = 4,
   parameter int TS_W       = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            a,
   output logic            q_valid,
   input  logic            q_ready,
   output logic [TS_W-1:0] q_ts,
   output logic            err,
   output logic            ovf
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);
   // The window counter holds the number of HOLD cycles still to come after the current one,
   // so the next pulse is legal exactly CT_CYCLES cycles after an accepted one.
   localparam logic [7:0] WIN_LOAD = (CT_CYCLES > 1) ? 8'(CT_CYCLES - 2) : 8'd0;

   typedef enum logic [1:0] {STARTUP, IDLE, HOLD, ERR} state_t;

   logic            s1, s2, s3;
   logic            detect;
   state_t          state;
   logic [1:0]      st_cnt;
   logic [7:0]      win;
   logic            accept;
   logic [TS_W-1:0] push_val;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= a;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign detect = s2 ^ s3;
   assign accept = detect && (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= STARTUP;
         st_cnt <= 2'd0;
         win    <= 8'd0;
         err    <= 1'b0;
      end else begin
         case (state)
            STARTUP: begin
               if (st_cnt == 2'd2) state <= IDLE;
               else                st_cnt <= st_cnt + 2'd1;
            end
            IDLE: begin
               if (detect && (CT_CYCLES > 1)) begin
                  win   <= WIN_LOAD;
                  state <= HOLD;
               end
            end
            HOLD: begin
               if (detect) begin
                  err   <= 1'b1;
                  state <= ERR;
               end else if (win == 8'd0) begin
                  state <= IDLE;
               end else begin
                  win <= win - 8'd1;
               end
            end
            ERR: state <= ERR;
            default: state <= STARTUP;
         endcase
      end
   end

`ifdef SFQRX_TIMESTAMP_EN
   logic [TS_W-1:0] cyc_cnt;

   always_ff @(posedge clk) begin
      if (rst) cyc_cnt <= '0;
      else     cyc_cnt <= cyc_cnt + TS_W'(1);
   end

   assign push_val = cyc_cnt;
`else
   logic [TS_W-1:0] seq_cnt;

   always_ff @(posedge clk) begin
      if (rst)         seq_cnt <= '0;
      else if (accept) seq_cnt <= seq_cnt + TS_W'(1);
   end

   assign push_val = seq_cnt;
`endif

   // Handshake: the head transfers on any rising edge where q_valid && q_ready; q_valid never
   // depends on q_ready, and q_ts stays stable while q_valid is high and q_ready is low.
   logic [TS_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]     wr_ptr, rd_ptr;
   logic            empty, full, pop, do_push;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop     = !empty && q_ready;
   assign do_push = accept && (!full || pop);
   assign q_valid = !empty;
   assign q_ts    = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!rst && do_push) mem[wr_ptr[AW-1:0]] <= push_val;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         ovf    <= 1'b0;
      end else begin
         if (do_push)                 wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)                     rd_ptr <= rd_ptr + PTR_ONE;
         if (accept && full && !pop)  ovf    <= 1'b1;
      end
   end

endmodule
